wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Writeback stage of the pipelined RV32I core. It is the writer end of the register-file write port (Wreg/rd/Wdata) consumed by the decode-stage register file. It captures retiring instructions from the MEM stage and selects the ALU result, the load data or PC+4. For loads it waits for the data-memory response and stalls upstream while waiting. It aligns and sign- or zero-extends load data, and times out hung loads.

Parameters:
LOAD_TIMEOUT, 255, maximum cycles spent in WAIT_LOAD before a load is abandoned (1..65535).

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
mem_valid  in  1  MEM stage presents an instruction this cycle
mem_regwrite  in  1  instruction writes rd
mem_rd  in  5  destination register
mem_wbsel  in  2  0=ALU result, 1=load, 2=PC+4, 3=reserved (treated as ALU)
mem_alu_result  in  32  ALU result; low 2 bits are the load byte offset
mem_pc4  in  32  PC+4 for JAL/JALR
mem_funct3  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU
flush  in  1  drop the MEM-stage instruction this cycle
dmem_rvalid  in  1  load data valid (single-cycle pulse)
dmem_rdata  in  32  load word, naturally word-aligned
wb_stall  out  1  upstream must hold the MEM stage
Wreg  out  1  register-file write enable
rd  out  5  register-file write address
Wdata  out  32  register-file write data
load_err  out  1  one-cycle pulse when a load times out

Behaviour:
- Reset (async, active-high): state=IDLE; Wreg=0; rd=0; Wdata=0; load_err=0; timeout counter=0; held load context cleared. Reset asserted mid-load abandons the load with no write. A dmem_rvalid arriving after reset releases is ignored.
- wb_stall = (state==WAIT_LOAD). It is combinational from state only.
- Accept condition: state==IDLE && mem_valid && !flush. If flush=1 in IDLE, the instruction is dropped and Wreg=0 on the next edge.
- IDLE, accept, mem_wbsel!=1: on the next edge Wreg <= mem_regwrite && (mem_rd!=0), rd <= mem_rd, and Wdata <= mem_pc4 if wbsel==2, else mem_alu_result. Latency is 1 cycle. Back-to-back accepts give consecutive one-cycle Wreg pulses.
- IDLE, accept, mem_wbsel==1: latch rd, regwrite, funct3 and offset=alu_result[1:0]. state <= WAIT_LOAD, Wreg <= 0, counter <= 0.
- IDLE, no accept: Wreg <= 0. rd and Wdata hold their previous values.
- WAIT_LOAD:
  - flush and mem_valid are ignored. The load is committed.
  - On dmem_rvalid: Wreg <= regwrite && rd!=0, Wdata <= extract(dmem_rdata), state <= IDLE. A new accept is possible only from the following cycle.
  - Otherwise, if counter == LOAD_TIMEOUT-1: load_err <= 1 for one cycle, Wreg <= 0, state <= IDLE.
  - Otherwise counter increments.
  - dmem_rvalid in the timeout cycle wins: the write happens and there is no error.
- Load extract:
  - LB/LBU: byte[offset], sign- or zero-extended.
  - LH/LHU: halfword[offset[1]] (offset[0] ignored), sign- or zero-extended.
  - LW: rdata unmodified, offset ignored.
  - funct3 3/6/7: rdata unmodified.
- dmem_rvalid in IDLE is ignored.
- rd==0 never produces Wreg=1, even when regwrite=1.
- load_err is 0 in every cycle other than its single pulse.

Test Plan:
- ALU op: mem_valid=1, wbsel=0, rd=5, alu_result=0x1234_5678, regwrite=1 -> next cycle Wreg=1, rd=5, Wdata=0x12345678; Wreg=0 the cycle after.
- Back-to-back: three ALU ops to rd 1,2,3 on consecutive cycles, plus one JAL with wbsel=2, pc4=0x104 -> four consecutive Wreg pulses with correct data; wb_stall stays 0.
- Load extension: for each of LB/LBU/LH/LHU/LW with dmem_rdata=0x80FF_7F01, sweep offset 0..3 (rvalid 3 cycles after accept):
  - LB offset 2 -> 0xFFFFFFFF.
  - LBU offset 3 -> 0x00000080.
  - LH offset 2 -> 0xFFFF80FF.
  - LHU offset 0 -> 0x00007F01.
  - wb_stall=1 for exactly 3 cycles.
- Flush/x0: flush=1 with a valid ALU op -> no Wreg. ALU op to rd=0 -> Wreg stays 0. flush=1 during WAIT_LOAD -> the load still writes.
- Timeout: LOAD_TIMEOUT=4, load with no rvalid -> load_err pulses on the 4th WAIT_LOAD cycle, no write, wb_stall drops. A late rvalid is ignored.
- Reset mid-load: assert Reset 2 cycles into WAIT_LOAD -> outputs zero immediately (async); post-reset rvalid produces no write.

Source files
------------

// File: rtl/wb_stage.sv
`timescale 1ns/1ps
// Writeback stage of the pipelined RV32I core: selects ALU, load or PC+4 data,
// waits for the data-memory response on loads and drives the register-file write port.
module wb_stage #(
  parameter int unsigned LOAD_TIMEOUT = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        mem_valid,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_wbsel,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_pc4,
  input  logic [2:0]  mem_funct3,
  input  logic        flush,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_stall,
  output logic        Wreg,
  output logic [4:0]  rd,
  output logic [31:0] Wdata,
  output logic        load_err
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_RSVD = 2'd3
  } wbsel_t;

  // Everything needed to finish a load once the memory answers.
  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic [2:0] funct3;
    logic [1:0] offset;
  } load_ctx_t;

  localparam int unsigned     CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  state_t           state, state_next;
  load_ctx_t        ctx, ctx_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             wreg_next;
  logic [4:0]       rd_next;
  logic [31:0]      wdata_next;
  logic             err_next;
  logic             accept;
  wbsel_t           wbsel;

  function automatic logic [31:0] load_extract(
    input logic [31:0] rdata,
    input logic [2:0]  funct3,
    input logic [1:0]  offset
  );
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] res;
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Halfword loads ignore offset[0]; only the word half is selectable.
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      3'd0:    res = {{24{byte_sel[7]}}, byte_sel};
      3'd4:    res = {24'b0, byte_sel};
      3'd1:    res = {{16{half_sel[15]}}, half_sel};
      3'd5:    res = {16'b0, half_sel};
      default: res = rdata;
    endcase
    return res;
  endfunction

  assign wbsel    = wbsel_t'(mem_wbsel);
  assign accept   = (state == IDLE) && mem_valid && !flush;
  assign wb_stall = (state == WAIT_LOAD);

  // NOTE: every variable is given a default before the case so no path leaves
  // one unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    ctx_next   = ctx;
    cnt_next   = cnt;
    wreg_next  = 1'b0;
    rd_next    = rd;
    wdata_next = Wdata;
    err_next   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (wbsel == WB_LOAD) begin
            ctx_next.rd       = mem_rd;
            ctx_next.regwrite = mem_regwrite;
            ctx_next.funct3   = mem_funct3;
            ctx_next.offset   = mem_alu_result[1:0];
            cnt_next          = '0;
            state_next        = WAIT_LOAD;
          end else begin
            wreg_next  = mem_regwrite && (mem_rd != 5'd0);
            rd_next    = mem_rd;
            wdata_next = (wbsel == WB_PC4) ? mem_pc4 : mem_alu_result;
          end
        end
      end

      WAIT_LOAD: begin
        // The load is committed: flush and mem_valid have no effect here, and a
        // response in the final timeout cycle still completes the load.
        if (dmem_rvalid) begin
          wreg_next  = ctx.regwrite && (ctx.rd != 5'd0);
          rd_next    = ctx.rd;
          wdata_next = load_extract(dmem_rdata, ctx.funct3, ctx.offset);
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ctx      <= '0;
      cnt      <= '0;
      Wreg     <= 1'b0;
      rd       <= 5'd0;
      Wdata    <= 32'd0;
      load_err <= 1'b0;
    end else begin
      ctx      <= ctx_next;
      cnt      <= cnt_next;
      Wreg     <= wreg_next;
      rd       <= rd_next;
      Wdata    <= wdata_next;
      load_err <= err_next;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
`timescale 1ns/1ps
// Self-checking bench for wb_stage: directed steps plus randomized traffic
// compared against an arithmetic model of writeback and load extraction.
module tb_wb_stage;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        mem_valid, mem_regwrite, flush, dmem_rvalid;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wbsel;
  logic [31:0] mem_alu_result, mem_pc4, dmem_rdata;
  logic [2:0]  mem_funct3;
  logic        wb_stall, Wreg, load_err;
  logic [4:0]  rd;
  logic [31:0] Wdata;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  localparam logic [31:0] PAT = 32'h80FF_7F01;

  wb_stage #(.LOAD_TIMEOUT(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .mem_wbsel(mem_wbsel), .mem_alu_result(mem_alu_result), .mem_pc4(mem_pc4),
    .mem_funct3(mem_funct3), .flush(flush),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_stall(wb_stall), .Wreg(Wreg), .rd(rd), .Wdata(Wdata), .load_err(load_err)
  );

  always #5 Clock = ~Clock;

  // Reference load semantics from the ISA rules, using plain integer arithmetic.
  function automatic logic [31:0] load_model(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
    longint word;
    longint v;
    int o;
    word = longint'(w);
    o = int'(off);
    case (f3)
      3'd0, 3'd4: begin
        v = (word / (longint'(1) << (8 * o))) % 256;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (word / (longint'(1) << (16 * (o / 2)))) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = word;
    endcase
    return 32'(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    mem_valid   = 1'b0;
    flush       = 1'b0;
    dmem_rvalid = 1'b0;
    mem_wbsel   = 2'd0;
  endtask

  task automatic issue(input logic [4:0] r, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic rw, input logic [2:0] f3);
    mem_valid      = 1'b1;
    flush          = 1'b0;
    mem_rd         = r;
    mem_wbsel      = sel;
    mem_alu_result = alu;
    mem_pc4        = pc4;
    mem_regwrite   = rw;
    mem_funct3     = f3;
  endtask

  // Non-load op: issue and check the write one cycle later; inputs stay driven.
  task automatic alu_step(input string tag, input logic [4:0] r, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] pc4, input logic rw);
    logic [31:0] exp_data;
    exp_data = (sel == 2'd2) ? pc4 : alu;
    issue(r, sel, alu, pc4, rw, 3'($urandom_range(0, 7)));
    tick();
    check({tag, ".wreg"},  32'(Wreg), 32'(rw && r != 5'd0));
    check({tag, ".rd"},    32'(rd), 32'(r));
    check({tag, ".data"},  Wdata, exp_data);
    check({tag, ".stall"}, 32'(wb_stall), 32'd0);
  endtask

  // Load: stall for lat+1 cycles, response in the last; noise 1 = valid+flush
  // during the wait, noise 2 = valid without flush during the wait.
  task automatic load_step(input string tag, input logic [4:0] r, input logic rw,
                           input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rdata,
                           input int lat, input int noise, input logic [31:0] exp_data);
    logic [31:0] addr;
    logic        exp_w;
    addr = $urandom();
    addr[1:0] = off;
    exp_w = rw && (r != 5'd0);
    issue(r, 2'd1, addr, $urandom(), rw, f3);
    tick();
    idle();
    for (int k = 0; k <= lat; k++) begin
      check({tag, ".stall_wait"}, 32'(wb_stall), 32'd1);
      check({tag, ".wreg_wait"},  32'(Wreg), 32'd0);
      if (noise != 0) begin
        issue(5'd9, 2'd0, 32'hDEAD_BEEF, 32'h0, 1'b1, 3'd0);
        flush = (noise == 1);
      end
      if (k == lat) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
      end
      tick();
    end
    idle();
    check({tag, ".wreg"},  32'(Wreg), 32'(exp_w));
    if (exp_w) check({tag, ".rd"}, 32'(rd), 32'(r));
    check({tag, ".data"},  Wdata, exp_data);
    check({tag, ".stall"}, 32'(wb_stall), 32'd0);
    check({tag, ".err"},   32'(load_err), 32'd0);
    tick();
    check({tag, ".after"}, 32'(Wreg), 32'd0);
  endtask

  initial begin
    logic [2:0] f3s [5];
    f3s = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    mem_rd = '0; mem_regwrite = 0; mem_alu_result = '0; mem_pc4 = '0;
    mem_funct3 = '0; dmem_rdata = '0;
    idle();
    Reset = 1'b1;
    #1;
    check("reset.wreg",  32'(Wreg), 32'd0);
    check("reset.rd",    32'(rd), 32'd0);
    check("reset.data",  Wdata, 32'd0);
    check("reset.stall", 32'(wb_stall), 32'd0);
    check("reset.err",   32'(load_err), 32'd0);
    tick();
    Reset = 1'b0;
    tick();

    // Single ALU op, then the write pulse ends while rd/Wdata hold.
    alu_step("alu", 5'd5, 2'd0, 32'h1234_5678, 32'h0, 1'b1);
    idle();
    tick();
    check("alu.pulse_end", 32'(Wreg), 32'd0);
    check("alu.rd_hold",   32'(rd), 32'd5);
    check("alu.data_hold", Wdata, 32'h1234_5678);

    // Back-to-back: four consecutive write pulses.
    alu_step("b2b1", 5'd1, 2'd0, 32'h0000_0011, 32'h0, 1'b1);
    alu_step("b2b2", 5'd2, 2'd0, 32'h0000_0022, 32'h0, 1'b1);
    alu_step("b2b3", 5'd3, 2'd3, 32'h0000_0033, 32'h0, 1'b1);
    alu_step("jal",  5'd1, 2'd2, 32'hFFFF_0000, 32'h0000_0104, 1'b1);
    idle();
    tick();

    // Load extension sweep against the model, rvalid 3 cycles after accept.
    foreach (f3s[i])
      for (int o = 0; o < 4; o++)
        load_step($sformatf("sweep_f%0d_o%0d", f3s[i], o), 5'd10, 1'b1, f3s[i], 2'(o), PAT,
                  2, 0, load_model(PAT, f3s[i], 2'(o)));
    load_step("lb_o2",  5'd11, 1'b1, 3'd0, 2'd2, PAT, 2, 0, 32'hFFFF_FFFF);
    load_step("lbu_o3", 5'd11, 1'b1, 3'd4, 2'd3, PAT, 2, 0, 32'h0000_0080);
    load_step("lh_o2",  5'd11, 1'b1, 3'd1, 2'd2, PAT, 2, 0, 32'hFFFF_80FF);
    load_step("lhu_o0", 5'd11, 1'b1, 3'd5, 2'd0, PAT, 2, 0, 32'h0000_7F01);

    // Flush and x0 handling.
    issue(5'd7, 2'd0, 32'hAAAA_5555, 32'h0, 1'b1, 3'd0);
    flush = 1'b1;
    tick();
    check("flush.wreg", 32'(Wreg), 32'd0);
    check("flush.rd",   32'(rd), 32'd11);
    alu_step("x0", 5'd0, 2'd0, 32'h5555_AAAA, 32'h0, 1'b1);
    idle();
    load_step("flush_wait", 5'd12, 1'b1, 3'd2, 2'd1, 32'hCAFE_F00D, 1, 1, 32'hCAFE_F00D);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_2222;
    tick();
    idle();
    check("idle_rvalid.wreg",  32'(Wreg), 32'd0);
    check("idle_rvalid.stall", 32'(wb_stall), 32'd0);

    // Timeout: error pulse after the 4th waiting cycle, late response ignored.
    issue(5'd13, 2'd1, 32'h0, 32'h0, 1'b1, 3'd2);
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      check("to.stall_wait", 32'(wb_stall), 32'd1);
      check("to.err_wait",   32'(load_err), 32'd0);
      tick();
    end
    check("to.err",   32'(load_err), 32'd1);
    check("to.wreg",  32'(Wreg), 32'd0);
    check("to.stall", 32'(wb_stall), 32'd0);
    dmem_rvalid = 1'b1;
    tick();
    idle();
    check("to.err_pulse", 32'(load_err), 32'd0);
    check("to.late_wreg", 32'(Wreg), 32'd0);
    load_step("to_edge", 5'd14, 1'b1, 3'd2, 2'd0, 32'h0BAD_CAFE, 3, 0, 32'h0BAD_CAFE);

    // Reset two cycles into a load.
    issue(5'd15, 2'd1, 32'h0, 32'h0, 1'b1, 3'd2);
    tick();
    idle();
    tick();
    tick();
    #2 Reset = 1'b1;
    #1;
    check("rst_mid.wreg",  32'(Wreg), 32'd0);
    check("rst_mid.rd",    32'(rd), 32'd0);
    check("rst_mid.data",  Wdata, 32'd0);
    check("rst_mid.stall", 32'(wb_stall), 32'd0);
    tick();
    Reset = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h7777_7777;
    tick();
    idle();
    check("rst_mid.post_wreg", 32'(Wreg), 32'd0);
    check("rst_mid.post_data", Wdata, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 2) begin
        logic [31:0] w;
        logic [2:0]  f3;
        logic [1:0]  off;
        w   = $urandom();
        f3  = 3'($urandom_range(0, 7));
        off = 2'($urandom_range(0, 3));
        load_step($sformatf("rnd_ld%0d", n), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  f3, off, w, $urandom_range(0, 3), $urandom_range(0, 2), load_model(w, f3, off));
      end else begin
        logic [1:0] sel;
        sel = (kind == 0) ? 2'd0 : (($urandom_range(0, 1) == 1) ? 2'd2 : 2'd3);
        alu_step($sformatf("rnd_op%0d", n), 5'($urandom_range(0, 31)), sel, $urandom(),
                 $urandom(), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 1) begin
          idle();
          tick();
          check("rnd.gap_wreg", 32'(Wreg), 32'd0);
        end
      end
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
